// File: rtl/dpu_pkg.sv
// rtl/dpu_pkg.sv - shared DPU types, constants and index-width helper
package dpu_pkg;

    typedef enum logic [0:0] {IDLE, SEND} dpu_unpack_state_t;

    localparam int OVF_CNT_W = 8;

    // Index registers never collapse to zero width, even for single-entry structures.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dpu_result_unpacker.sv
// rtl/dpu_result_unpacker.sv - packed result frame to word stream unpacker (optional m_last via DPU_UNPACK_LAST_EN)
module dpu_result_unpacker
    import dpu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     in_valid,
    input  logic [2*WIDTH*DEPTH-1:0] in_data,
    output logic                     in_ready,
    output logic                     m_valid,
    output logic [2*WIDTH-1:0]       m_data,
    input  logic                     m_ready,
    output logic                     busy,
    output logic [OVF_CNT_W-1:0]     ovf_cnt
`ifdef DPU_UNPACK_LAST_EN
    ,
    output logic                     m_last
`endif
);

    localparam int WW    = 2 * WIDTH;
    localparam int FW    = WW * DEPTH;
    localparam int IDX_W = idx_width(DEPTH);
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [OVF_CNT_W-1:0] OVF_MAX  = '1;

    dpu_unpack_state_t state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [FW-1:0]     frame_q, frame_d;

    logic xfer;
    logic capture;
    logic drop;

    // A new frame may land while idle, or in the very cycle the last word leaves.
    assign in_ready = (state_q == IDLE) ||
                      ((state_q == SEND) && (idx_q == LAST_IDX) && m_ready);

    assign xfer    = m_valid && m_ready;
    assign capture = in_valid && in_ready;
    assign drop    = in_valid && !in_ready;

    // The head of the shift buffer is always the word on offer.
    assign m_data = frame_q[WW-1:0];

    // Next-state: drain on transfer, then let a capture override buffer, index and state.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        frame_d = frame_q;
        if (xfer) begin
            frame_d = frame_q >> WW;
            if (idx_q != LAST_IDX) begin
                idx_d = idx_q + 1'b1;
            end else begin
                idx_d   = '0;
                state_d = IDLE;
            end
        end
        if (capture) begin
            frame_d = in_data;
            idx_d   = '0;
            state_d = SEND;
        end
    end

    // State, buffer and registered stream outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            frame_q <= '0;
            m_valid <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            m_valid <= (state_d == SEND);
            busy    <= (state_d == SEND);
        end
    end

    // Dropped-frame counter; the producer cannot be stalled, so losses are only counted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf_cnt <= '0;
        end else if (drop && (ovf_cnt != OVF_MAX)) begin
            ovf_cnt <= ovf_cnt + 1'b1;
        end
    end

`ifdef DPU_UNPACK_LAST_EN
    // Frame delimiter registered in step with the word it marks.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_last <= 1'b0;
        end else begin
            m_last <= (state_d == SEND) && (idx_d == LAST_IDX);
        end
    end
`endif

endmodule

// File: tb/tb_dpu_result_unpacker.sv
// tb/tb_dpu_result_unpacker.sv - randomized and directed bench with queue reference model
module tb_dpu_result_unpacker;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int WW    = 2 * WIDTH;

    logic                  clk = 1'b0;
    logic                  rstn;
    logic                  in_valid;
    logic [WW*DEPTH-1:0]   in_data;
    logic                  in_ready;
    logic                  m_valid;
    logic [WW-1:0]         m_data;
    logic                  m_ready;
    logic                  busy;
    logic [7:0]            ovf_cnt;
`ifdef DPU_UNPACK_LAST_EN
    logic                  m_last;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model: words still owed to the consumer, and the drop count.
    logic [WW-1:0] pend[$];
    int            exp_ovf = 0;

    always #5 clk = ~clk;

    dpu_result_unpacker #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_ready  (m_ready),
        .busy     (busy),
        .ovf_cnt  (ovf_cnt)
`ifdef DPU_UNPACK_LAST_EN
        ,
        .m_last   (m_last)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive inputs at the falling edge, compare against the model, advance the model.
    task automatic step(input logic iv, input logic [WW*DEPTH-1:0] d, input logic mr);
        logic          e_valid;
        logic [WW-1:0] e_data;
        logic          e_rdy;
        @(negedge clk);
        in_valid = iv;
        in_data  = d;
        m_ready  = mr;
        #1;
        e_valid = (pend.size() > 0);
        e_data  = e_valid ? pend[0] : '0;
        e_rdy   = (pend.size() == 0) || (pend.size() == 1 && mr);
        check_eq("m_valid",  32'(m_valid),  32'(e_valid));
        check_eq("m_data",   32'(m_data),   32'(e_data));
        check_eq("busy",     32'(busy),     32'(e_valid));
        check_eq("in_ready", 32'(in_ready), 32'(e_rdy));
        check_eq("ovf_cnt",  32'(ovf_cnt),  32'(exp_ovf));
`ifdef DPU_UNPACK_LAST_EN
        check_eq("m_last",   32'(m_last),   32'(pend.size() == 1));
`endif
        if (e_valid && mr) void'(pend.pop_front());
        if (iv && e_rdy) begin
            for (int k = 0; k < DEPTH; k++) pend.push_back(d[WW*k +: WW]);
        end else if (iv) begin
            if (exp_ovf < 255) exp_ovf++;
        end
    endtask

    localparam logic [63:0] FRAME_A = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    localparam logic [63:0] FRAME_B = {16'h00D0, 16'h00C0, 16'h00B0, 16'h00A0};

    initial begin
        rstn     = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        m_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_m_valid", 32'(m_valid), 0);
        check_eq("rst_busy",    32'(busy),    0);
        check_eq("rst_ovf",     32'(ovf_cnt), 0);
        check_eq("rst_m_data",  32'(m_data),  0);
        @(negedge clk);
        rstn = 1'b1;

        // Basic stream
        step(1'b1, FRAME_A, 1'b1);
        repeat (5) step(1'b0, '0, 1'b1);

        // Backpressure: stall while word 0002 is on offer
        step(1'b1, FRAME_A, 1'b1);
        step(1'b0, '0, 1'b1);
        repeat (3) step(1'b0, '0, 1'b0);
        repeat (4) step(1'b0, '0, 1'b1);

        // Back-to-back: second frame arrives with the last transfer of the first
        step(1'b1, FRAME_A, 1'b1);
        repeat (3) step(1'b0, '0, 1'b1);
        step(1'b1, FRAME_B, 1'b1);
        repeat (5) step(1'b0, '0, 1'b1);

        // Overflow during a stream
        step(1'b1, FRAME_A, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b1, FRAME_B, 1'b1);
        step(1'b1, FRAME_B, 1'b1);
        repeat (3) step(1'b0, '0, 1'b1);
        check_eq("ovf_two", 32'(ovf_cnt), 2);

        // Saturation: hold the stream stalled and hammer with frames
        step(1'b1, FRAME_A, 1'b0);
        repeat (300) step(1'b1, FRAME_B, 1'b0);
        step(1'b0, '0, 1'b0);
        check_eq("ovf_sat", 32'(ovf_cnt), 255);
        repeat (5) step(1'b0, '0, 1'b1);

        // Reset mid-frame after word 0002 transfers
        step(1'b1, FRAME_A, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check_eq("mid_rst_m_valid", 32'(m_valid), 0);
        check_eq("mid_rst_busy",    32'(busy),    0);
        check_eq("mid_rst_ovf",     32'(ovf_cnt), 0);
        pend.delete();
        exp_ovf = 0;
        @(negedge clk);
        rstn = 1'b1;
        step(1'b1, FRAME_B, 1'b1);
        repeat (5) step(1'b0, '0, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [63:0] d;
            d = {$urandom, $urandom};
            step(($urandom % 4) == 0, d, ($urandom % 3) != 0);
        end
        repeat (8) step(1'b0, '0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
